// File: rtl/armleo_mem_1rwm.sv
// Request/response front-end for armleo_mem_1rwm: one issue stage (s1) capturing the
// 1-cycle memory read, followed by a 2-entry in-order response FIFO.
module armleo_mem_1rwm_ctrl #(
  parameter int DEPTH_LOG2 = 7,
  parameter int WIDTH      = 32,
  parameter int GRANULITY  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [DEPTH_LOG2-1:0]         req_address,
  input  logic [WIDTH/GRANULITY-1:0]    req_writeenable,
  input  logic [WIDTH-1:0]              req_writedata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_write,
  output logic [WIDTH-1:0]              rsp_readdata,
  output logic [DEPTH_LOG2-1:0]         mem_address,
  output logic                          mem_read,
  input  logic [WIDTH-1:0]              mem_readdata,
  output logic                          mem_write,
  output logic [WIDTH/GRANULITY-1:0]    mem_writeenable,
  output logic [WIDTH-1:0]              mem_writedata
);

`ifdef SIMULATION
  if (WIDTH % GRANULITY != 0) begin : g_bad_granulity
    $fatal(1, "WIDTH must be a multiple of GRANULITY");
  end
`endif

  typedef struct packed {
    logic             write;
    logic [WIDTH-1:0] data;
  } rsp_t;

  rsp_t [1:0] fifo;
  logic       wptr, rptr;
  logic [1:0] count;
  logic       s1_valid, s1_write;
  logic       issue, push, pop;

  // Stall only when s1 has nowhere to go; a same-cycle pop is deliberately ignored
  // so rsp_ready never reaches req_ready combinationally.
  assign req_ready = !rst && !(s1_valid && count == 2'd2);
  assign issue     = req_valid && req_ready;

  assign mem_read        = issue && !req_write;
  assign mem_write       = issue && req_write;
  assign mem_address     = req_address;
  assign mem_writeenable = req_writeenable;
  assign mem_writedata   = req_writedata;

  assign rsp_valid    = count != 2'd0;
  assign rsp_write    = rsp_valid && fifo[rptr].write;
  assign rsp_readdata = rsp_valid ? fifo[rptr].data : '0;

  assign pop  = rsp_valid && rsp_ready;
  assign push = s1_valid && (count != 2'd2 || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_write <= 1'b0;
      count    <= 2'd0;
      wptr     <= 1'b0;
      rptr     <= 1'b0;
    end else begin
      if (issue) begin
        s1_valid <= 1'b1;
        s1_write <= req_write;
      end else if (push) begin
        s1_valid <= 1'b0;
      end
      // mem_readdata is still valid while s1 stalls: no read can issue then.
      if (push) begin
        fifo[wptr].write <= s1_write;
        fifo[wptr].data  <= s1_write ? '0 : mem_readdata;
        wptr             <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_armleo_mem_1rwm_ctrl.sv
// Directed bench for armleo_mem_1rwm_ctrl with a behavioural read-first memory attached.
module tb_armleo_mem_1rwm_ctrl;
  localparam int DL = 7, W = 32, G = 8, L = W / G;

  logic          clk = 1'b0, rst = 1'b1;
  logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [DL-1:0] req_address = '0;
  logic [L-1:0]  req_writeenable = '0;
  logic [W-1:0]  req_writedata = '0;
  logic          rsp_valid, rsp_ready = 1'b1, rsp_write;
  logic [W-1:0]  rsp_readdata;
  logic [DL-1:0] mem_address;
  logic          mem_read, mem_write;
  logic [W-1:0]  mem_readdata = '0;
  logic [L-1:0]  mem_writeenable;
  logic [W-1:0]  mem_writedata;

  int total = 0, bad = 0;
  logic [W-1:0] mem [0:(1<<DL)-1];

  armleo_mem_1rwm_ctrl #(.DEPTH_LOG2(DL), .WIDTH(W), .GRANULITY(G)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_writeenable(req_writeenable), .req_writedata(req_writedata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_readdata(rsp_readdata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_readdata(mem_readdata),
    .mem_write(mem_write), .mem_writeenable(mem_writeenable), .mem_writedata(mem_writedata)
  );

  always #5 clk = ~clk;

  // read-first memory, readdata held until the next read
  always @(posedge clk) begin
    if (mem_read) mem_readdata <= mem[mem_address];
    if (mem_write)
      for (int l = 0; l < L; l++)
        if (mem_writeenable[l]) mem[mem_address][l*G +: G] <= mem_writedata[l*G +: G];
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    req_valid = 1'b1; req_write = 1'b0; req_address = 7'd3;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold cyc%0d: ready=%b rsp_valid=%b rd=%b wr=%b, need 0 0 0 0",
                 i, req_ready, rsp_valid, mem_read, mem_write);
      end
    end
    req_valid = 1'b0; rst = 1'b0;
    step();
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_write !== 1'b0 || rsp_readdata !== '0) begin
      bad++;
      $display("FAIL reset_release: ready=%b rsp_valid=%b rsp_write=%b data=%h, need 1 0 0 0",
               req_ready, rsp_valid, rsp_write, rsp_readdata);
    end
  endtask

  // write then read the same address back-to-back
  task automatic write_then_read(input logic [L-1:0] we, input logic [W-1:0] wd,
                                 input logic [W-1:0] expd, input string nm);
    req_valid = 1'b1; req_write = 1'b1; req_address = 7'd5; req_writeenable = we; req_writedata = wd;
    #1;
    total++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 7'd5 || mem_writeenable !== we) begin
      bad++;
      $display("FAIL %s_issue_wr: wr=%b rd=%b addr=%0d we=%b, need 1 0 5 %b",
               nm, mem_write, mem_read, mem_address, mem_writeenable, we);
    end
    step();
    req_write = 1'b0;
    #1;
    total++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0) begin
      bad++;
      $display("FAIL %s_issue_rd: rd=%b wr=%b, need 1 0", nm, mem_read, mem_write);
    end
    step();
    req_valid = 1'b0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_readdata !== '0) begin
      bad++;
      $display("FAIL %s_ack: valid=%b write=%b data=%h, need 1 1 0", nm, rsp_valid, rsp_write, rsp_readdata);
    end
    step();
    total++;
    if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_readdata !== expd) begin
      bad++;
      $display("FAIL %s_rdata: valid=%b write=%b data=%h, need 1 0 %h",
               nm, rsp_valid, rsp_write, rsp_readdata, expd);
    end
    step();
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_drain: rsp_valid=%b, need 0", nm, rsp_valid);
    end
  endtask

  task automatic test_write_read();
    write_then_read(4'b1111, 32'hA5A5A5A5, 32'hA5A5A5A5, "full");
  endtask

  task automatic test_partial_write();
    write_then_read(4'b0010, 32'h00003C00, 32'hA5A53CA5, "partial");
  endtask

  task automatic test_backpressure();
    logic [W-1:0] got [$];
    logic         exp_rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int           acc = 0;
    logic         issued;
    rsp_ready = 1'b0; req_valid = 1'b1; req_write = 1'b0;
    for (int k = 0; k < 6; k++) begin
      req_address = 7'(1 + acc);
      #1;
      total++;
      if (req_ready !== exp_rdy[k]) begin
        bad++;
        $display("FAIL bp_ready cyc%0d: ready=%b, need %b", k, req_ready, exp_rdy[k]);
      end
      if (req_ready) acc++;
      step();
    end
    total++;
    if (acc != 3) begin
      bad++;
      $display("FAIL bp_accepted: accepted=%0d, need 3", acc);
    end
    req_address = 7'd4;
    rsp_ready = 1'b1;
    issued = 1'b0;
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      #1;
      if (rsp_valid) begin
        got.push_back(rsp_readdata);
        total++;
        if (rsp_write !== 1'b0) begin
          bad++;
          $display("FAIL bp_rsp_kind %0d: write=%b, need 0", got.size(), rsp_write);
        end
      end
      issued = req_valid && req_ready;
      step();
      if (issued) req_valid = 1'b0;
    end
    total++;
    if (got.size() != 4) begin
      bad++;
      $display("FAIL bp_count: responses=%0d, need 4", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      total++;
      if (got[i] !== 32'h10000001 + 32'(i)) begin
        bad++;
        $display("FAIL bp_order %0d: data=%h, need %h", i, got[i], 32'h10000001 + 32'(i));
      end
    end
    req_valid = 1'b0;
    step(); step();
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_dup: rsp_valid=%b, need 0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1; req_write = 1'b0;
    for (int k = 0; k < 18; k++) begin
      req_valid   = (k < 16);
      req_address = 7'(16 + k);
      #1;
      if (k < 16) begin
        total++;
        if (req_ready !== 1'b1) begin
          bad++;
          $display("FAIL b2b_ready cyc%0d: ready=%b, need 1", k, req_ready);
        end
      end
      if (k >= 2) begin
        total++;
        if (rsp_valid !== 1'b1 || rsp_readdata !== 32'h10000000 + 32'(16 + k - 2)) begin
          bad++;
          $display("FAIL b2b_rsp cyc%0d: valid=%b data=%h, need 1 %h",
                   k, rsp_valid, rsp_readdata, 32'h10000000 + 32'(16 + k - 2));
        end
      end else begin
        total++;
        if (rsp_valid !== 1'b0) begin
          bad++;
          $display("FAIL b2b_latency cyc%0d: valid=%b, need 0", k, rsp_valid);
        end
      end
      step();
    end
    req_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_midop();
    rsp_ready = 1'b0; req_valid = 1'b1; req_write = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_address = 7'(1 + k);
      step();
    end
    req_valid = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_full: ready=%b rsp_valid=%b, need 0 1", req_ready, rsp_valid);
    end
    rst = 1'b1;
    step();
    total++;
    if (rsp_valid !== 1'b0 || dut.count !== 2'd0 || req_ready !== 1'b0 || rsp_readdata !== '0) begin
      bad++;
      $display("FAIL mid_reset: rsp_valid=%b count=%0d ready=%b data=%h, need 0 0 0 0",
               rsp_valid, dut.count, req_ready, rsp_readdata);
    end
    rst = 1'b0;
    rsp_ready = 1'b1;
    step();
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_stale: rsp_valid=%b ready=%b, need 0 1", rsp_valid, req_ready);
    end
    req_valid = 1'b1; req_address = 7'd7;
    step();
    req_valid = 1'b0;
    step();
    total++;
    if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_readdata !== 32'h10000007) begin
      bad++;
      $display("FAIL mid_after: valid=%b write=%b data=%h, need 1 0 10000007",
               rsp_valid, rsp_write, rsp_readdata);
    end
    step();
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_after_drain: rsp_valid=%b, need 0", rsp_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << DL); i++) mem[i] = 32'h10000000 + 32'(i);
    test_reset();
    test_write_read();
    test_partial_write();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded, need completion");
    $fatal(1, "timeout");
  end
endmodule
